// File: rtl/lemming_if.sv
// Walker-FSM <-> world signal bundle: status in, terrain stimulus and coordinates out.
// The world drives the slave side; the walker (or a bench) drives the master side.
interface lemming_if;
  logic       walk_left;
  logic       walk_right;
  logic       aaah;
  logic       digging;
  logic       dig_req;
  logic       ground;
  logic       bump_left;
  logic       bump_right;
  logic       dig;
  logic [3:0] pos;
  logic [4:0] depth;
  logic       splat;
  logic       illegal;

  modport master (
    output walk_left, walk_right, aaah, digging, dig_req,
    input  ground, bump_left, bump_right, dig, pos, depth, splat, illegal
  );

  modport slave (
    input  walk_left, walk_right, aaah, digging, dig_req,
    output ground, bump_left, bump_right, dig, pos, depth, splat, illegal
  );
endinterface

// File: rtl/lemming_world.sv
// Terrain model for a single lemming: a row of diggable columns above a bedrock
// tunnel, tracking position, depth, fall length and sticky splat/illegal flags.
module lemming_world #(
  parameter int          TRACK_LEN   = 16,
  parameter int          START_POS   = 8,
  parameter logic [15:0] HOLE_INIT   = 16'h0000,
  parameter int          FLOOR_DEPTH = 12,
  parameter int          DIG_CYCLES  = 3,
  parameter int          SPLAT_LEN   = 20
) (
  input  logic clk,
  input  logic areset_n,
  lemming_if.slave lw
);

  localparam logic [3:0] LP_START    = 4'(START_POS);
  localparam logic [3:0] LP_LAST     = 4'(TRACK_LEN - 1);
  localparam logic [3:0] LP_DIG_LAST = 4'(DIG_CYCLES - 1);
  localparam logic [4:0] LP_FLOOR    = 5'(FLOOR_DEPTH);
  // Fall length saturates at 31, so a threshold above that can never be reached.
  localparam int         LP_SPLAT_SAT = (SPLAT_LEN > 31) ? 32 : SPLAT_LEN;
  localparam logic [5:0] LP_SPLAT     = 6'(LP_SPLAT_SAT);

  logic [3:0]  r_pos;
  logic [4:0]  r_depth;
  logic [15:0] r_open;
  logic [3:0]  r_dig_cnt;
  logic [4:0]  r_fall_len;
  logic        r_dig;
  logic        r_splat;
  logic        r_illegal;

  logic [3:0]  w_pos_next;
  logic        w_at_floor;
  logic        w_ground;
  logic        w_pos_moves;
  logic        w_dig_active;
  logic        w_dig_done;
  logic        w_multi;
  logic        w_after_splat;

  assign w_at_floor  = (r_depth == LP_FLOOR);
  assign w_ground    = w_at_floor | ~r_open[r_pos];
  assign w_pos_moves = (w_pos_next != r_pos);

  always_comb begin
    w_pos_next = r_pos;
    if (w_ground) begin
      if (lw.walk_left && (r_pos != 4'd0))
        w_pos_next = r_pos - 4'd1;
      else if (lw.walk_right && (r_pos != LP_LAST))
        w_pos_next = r_pos + 4'd1;
    end
  end

  // Digging progresses only while standing still above bedrock on a closed column.
  assign w_dig_active = lw.digging && !w_at_floor && !w_pos_moves && !r_open[r_pos];
  assign w_dig_done   = w_dig_active && (r_dig_cnt == LP_DIG_LAST);

  assign w_multi       = ($countones({lw.walk_left, lw.walk_right, lw.aaah, lw.digging}) > 1);
  assign w_after_splat = r_splat && (lw.walk_left || lw.walk_right || lw.digging);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_pos <= LP_START;
    end else begin
      r_pos <= w_pos_next;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_depth <= 5'd0;
    end else if (lw.aaah && (r_depth < LP_FLOOR)) begin
      r_depth <= r_depth + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_dig_cnt <= 4'd0;
    end else if (!lw.digging || w_pos_moves || w_at_floor) begin
      r_dig_cnt <= 4'd0;
    end else if (w_dig_active) begin
      r_dig_cnt <= w_dig_done ? 4'd0 : r_dig_cnt + 4'd1;
    end
  end

  // Each column bit only ever opens; reset restores the initial hole map.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_col
      always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
          r_open[gi] <= HOLE_INIT[gi];
        end else if (w_dig_done && (r_pos == 4'(gi))) begin
          r_open[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_fall_len <= 5'd0;
    end else if (!lw.aaah) begin
      r_fall_len <= 5'd0;
    end else if (!w_ground && (r_fall_len != 5'd31)) begin
      r_fall_len <= r_fall_len + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_dig     <= 1'b0;
      r_splat   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_dig <= lw.dig_req;
      if (lw.aaah && w_ground && ({1'b0, r_fall_len} >= LP_SPLAT))
        r_splat <= 1'b1;
      if (w_multi || w_after_splat)
        r_illegal <= 1'b1;
    end
  end

  assign lw.ground     = w_ground;
  assign lw.bump_left  = lw.walk_left && (r_pos == 4'd0);
  assign lw.bump_right = lw.walk_right && (r_pos == LP_LAST);
  assign lw.dig        = r_dig;
  assign lw.pos        = r_pos;
  assign lw.depth      = r_depth;
  assign lw.splat      = r_splat;
  assign lw.illegal    = r_illegal;

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench: a vector table on a default world plus hand-written fall,
// dig and reset-abort sequences on two differently parameterised worlds.
module tb_lemming_world;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  logic rst_c_n;

  lemming_if if_a ();
  lemming_if if_b ();
  lemming_if if_c ();

  lemming_world dut_a (.clk(clk), .areset_n(rst_a_n), .lw(if_a.slave));
  lemming_world #(.HOLE_INIT(16'h0080)) dut_b (.clk(clk), .areset_n(rst_b_n), .lw(if_b.slave));
  lemming_world #(.FLOOR_DEPTH(24)) dut_c (.clk(clk), .areset_n(rst_c_n), .lw(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wl, wr, aa, dg, dr;
    logic [3:0] pos;
    logic [4:0] depth;
    logic       gnd, bl, br, dig, spl, ill;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] ins, input logic [3:0] p, input logic [4:0] d,
                              input logic [5:0] outs);
    vec_t v;
    {v.wl, v.wr, v.aa, v.dg, v.dr} = ins;
    v.pos   = p;
    v.depth = d;
    {v.gnd, v.bl, v.br, v.dig, v.spl, v.ill} = outs;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs {wl,wr,aa,dg,dr}; outputs {gnd,bl,br,dig,spl,ill}
    for (int i = 0; i < 7; i++) vecs[i] = mk(5'b10000, 4'(7 - i), 5'd0, 6'b100000);
    vecs[7]  = mk(5'b10000, 4'd0, 5'd0, 6'b110000);
    vecs[8]  = mk(5'b10000, 4'd0, 5'd0, 6'b110000);
    vecs[9]  = mk(5'b01000, 4'd1, 5'd0, 6'b100000);
    vecs[10] = mk(5'b00010, 4'd1, 5'd0, 6'b100000);
    vecs[11] = mk(5'b00010, 4'd1, 5'd0, 6'b100000);
    vecs[12] = mk(5'b00000, 4'd1, 5'd0, 6'b100000);
    vecs[13] = mk(5'b00010, 4'd1, 5'd0, 6'b100000);
    vecs[14] = mk(5'b00010, 4'd1, 5'd0, 6'b100000);
    vecs[15] = mk(5'b00010, 4'd1, 5'd0, 6'b000000);
    vecs[16] = mk(5'b00001, 4'd1, 5'd0, 6'b000100);
    vecs[17] = mk(5'b00000, 4'd1, 5'd0, 6'b000000);
    vecs[18] = mk(5'b00100, 4'd1, 5'd1, 6'b000000);
    vecs[19] = mk(5'b10100, 4'd1, 5'd2, 6'b000001);
    vecs[20] = mk(5'b00100, 4'd1, 5'd3, 6'b000001);

    {if_a.walk_left, if_a.walk_right, if_a.aaah, if_a.digging, if_a.dig_req} = 5'b0;
    {if_b.walk_left, if_b.walk_right, if_b.aaah, if_b.digging, if_b.dig_req} = 5'b0;
    {if_c.walk_left, if_c.walk_right, if_c.aaah, if_c.digging, if_c.dig_req} = 5'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    rst_c_n = 1'b0;
    #12;

    chk("rst_a_pos", 32'(if_a.pos), 32'd8);
    chk("rst_a_depth", 32'(if_a.depth), 32'd0);
    chk("rst_a_ground", 32'(if_a.ground), 32'd1);
    chk("rst_a_flags", 32'({if_a.dig, if_a.splat, if_a.illegal}), 32'd0);
    chk("rst_b_ground", 32'(if_b.ground), 32'd1);

    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    rst_c_n = 1'b1;

    // Default world: walk to the left wall, dig, dig_req latency, illegal combo
    for (int i = 0; i < NV; i++) begin
      {if_a.walk_left, if_a.walk_right, if_a.aaah, if_a.digging, if_a.dig_req} =
        {vecs[i].wl, vecs[i].wr, vecs[i].aa, vecs[i].dg, vecs[i].dr};
      step();
      $display("[TB] vec %0d pos=%0d depth=%0d ground=%0d bump=%0d%0d dig=%0d splat=%0d illegal=%0d",
               i, if_a.pos, if_a.depth, if_a.ground, if_a.bump_left, if_a.bump_right,
               if_a.dig, if_a.splat, if_a.illegal);
      chk($sformatf("vec%0d_pos", i), 32'(if_a.pos), 32'(vecs[i].pos));
      chk($sformatf("vec%0d_depth", i), 32'(if_a.depth), 32'(vecs[i].depth));
      chk($sformatf("vec%0d_outs", i),
          32'({if_a.ground, if_a.bump_left, if_a.bump_right, if_a.dig, if_a.splat, if_a.illegal}),
          32'({vecs[i].gnd, vecs[i].bl, vecs[i].br, vecs[i].dig, vecs[i].spl, vecs[i].ill}));
    end

    // Pre-opened column 7: step into it and fall to the bedrock at depth 12
    if_b.walk_left = 1'b1;
    step();
    chk("b_pos7", 32'(if_b.pos), 32'd7);
    chk("b_ground_hole", 32'(if_b.ground), 32'd0);
    if_b.walk_left = 1'b0;
    if_b.aaah = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("b_fall_depth%0d", k), 32'(if_b.depth), 32'(k));
      chk($sformatf("b_fall_ground%0d", k), 32'(if_b.ground), (k == 12) ? 32'd1 : 32'd0);
    end
    step();
    $display("[TB] b landing depth=%0d splat=%0d", if_b.depth, if_b.splat);
    chk("b_land_depth", 32'(if_b.depth), 32'd12);
    chk("b_land_splat", 32'(if_b.splat), 32'd0);
    if_b.aaah = 1'b0;

    // Deep world: dig column 8, fall 24 rows, splat at landing
    if_c.digging = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("c_dig_ground%0d", k), 32'(if_c.ground), (k == 3) ? 32'd0 : 32'd1);
    end
    if_c.digging = 1'b0;
    if_c.aaah = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("c_fall_depth%0d", k), 32'(if_c.depth), 32'(k));
      chk($sformatf("c_fall_splat%0d", k), 32'(if_c.splat), 32'd0);
    end
    chk("c_floor_ground", 32'(if_c.ground), 32'd1);
    step();
    $display("[TB] c landing depth=%0d splat=%0d", if_c.depth, if_c.splat);
    chk("c_land_splat", 32'(if_c.splat), 32'd1);
    if_c.aaah = 1'b0;
    step();
    chk("c_splat_sticky", 32'(if_c.splat), 32'd1);
    chk("c_no_illegal", 32'(if_c.illegal), 32'd0);

    // Reset clears splat and the dug column; then abort a fall at depth 5
    @(negedge clk);
    rst_c_n = 1'b0;
    #1;
    chk("c_rst_splat", 32'(if_c.splat), 32'd0);
    chk("c_rst_ground", 32'(if_c.ground), 32'd1);
    @(negedge clk);
    rst_c_n = 1'b1;
    if_c.digging = 1'b1;
    repeat (3) step();
    if_c.digging = 1'b0;
    if_c.aaah = 1'b1;
    repeat (5) step();
    chk("c_mid_depth5", 32'(if_c.depth), 32'd5);
    #2;
    rst_c_n = 1'b0;
    #1;
    $display("[TB] c async reset depth=%0d pos=%0d ground=%0d", if_c.depth, if_c.pos, if_c.ground);
    chk("c_abort_depth", 32'(if_c.depth), 32'd0);
    chk("c_abort_pos", 32'(if_c.pos), 32'd8);
    chk("c_abort_ground", 32'(if_c.ground), 32'd1);
    if_c.aaah = 1'b0;
    @(negedge clk);
    rst_c_n = 1'b1;

    // Reset mid-dig discards partial progress
    if_c.digging = 1'b1;
    repeat (2) step();
    @(negedge clk);
    rst_c_n = 1'b0;
    @(negedge clk);
    rst_c_n = 1'b1;
    step();
    chk("c_dig_restart1", 32'(if_c.ground), 32'd1);
    step();
    chk("c_dig_restart2", 32'(if_c.ground), 32'd1);
    step();
    chk("c_dig_restart3", 32'(if_c.ground), 32'd0);
    if_c.digging = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lemming_world.md
LEMMING_WORLD -- requirements
Module: lemming_world

Interface
REQ-001 The module SHALL have parameter TRACK_LEN, default 16, meaning number of columns (positions 0..TRACK_LEN-1, 2..16).
REQ-002 The module SHALL have parameter START_POS, default 8, meaning column occupied after reset.
REQ-003 The module SHALL have parameter HOLE_INIT, default 16'h0000, meaning per-column open-shaft map after reset (bit i = column i open).
REQ-004 The module SHALL have parameter FLOOR_DEPTH, default 12, meaning depth of bedrock tunnel (1..31).
REQ-005 The module SHALL have parameter DIG_CYCLES, default 3, meaning consecutive digging cycles needed to open a column (1..15).
REQ-006 The module SHALL have parameter SPLAT_LEN, default 20, meaning fall length at or above which landing counts as fatal.
REQ-007 The module SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-008 The module SHALL have port areset_n  input  1  asynchronous active-low reset.
REQ-009 The module SHALL have ports walk_left, walk_right, aaah, digging  input  1 each  lemming status from the walker FSM.
REQ-010 The module SHALL have port dig_req  input  1  operator dig command.
REQ-011 The module SHALL have ports ground, bump_left, bump_right, dig  output  1 each  stimulus to the walker FSM.
REQ-012 The module SHALL have ports pos [3:0] and depth [4:0]  output  lemming coordinates.
REQ-013 The module SHALL have ports splat and illegal  output  1 each  sticky status flags.

Function
REQ-014 ground SHALL be combinational from registers: 1 when depth==FLOOR_DEPTH, else NOT open[pos].
REQ-015 bump_left SHALL equal walk_left AND pos==0; bump_right SHALL equal walk_right AND pos==TRACK_LEN-1 (combinational, no flop).
REQ-016 dig SHALL be dig_req registered once (one-cycle latency).
REQ-017 At each edge with ground==1: walk_left AND pos>0 -> pos-1; walk_right AND pos<TRACK_LEN-1 -> pos+1; otherwise pos holds.
REQ-018 At each edge with aaah==1 AND depth<FLOOR_DEPTH, depth SHALL increment by 1; depth SHALL never decrement except by reset.
REQ-019 dig_cnt (4 bits) SHALL increment at edges with digging==1, depth<FLOOR_DEPTH, open[pos]==0; at edges where it equals DIG_CYCLES-1 it SHALL set open[pos]=1 and clear to 0 instead.
REQ-020 dig_cnt SHALL clear at any edge where digging==0, pos changes, or depth==FLOOR_DEPTH (bedrock is undiggable; digging there has no effect).
REQ-021 fall_len (5 bits) SHALL increment, saturating at 31, at edges with aaah==1 AND ground==0, and clear at edges with aaah==0.
REQ-022 splat SHALL set at an edge with aaah==1, ground==1, fall_len>=SPLAT_LEN, and hold until reset.
REQ-023 illegal SHALL set at an edge where more than one of walk_left, walk_right, aaah, digging is 1, or where walk/dig activity follows splat, and hold until reset.
REQ-024 open[] bits SHALL only go 0->1 during operation; no column closes.
REQ-025 Simultaneous walk and aaah (illegal) SHALL still apply REQ-017/018 independently and set illegal.

Reset
REQ-026 While areset_n==0, pos=START_POS, depth=0, open=HOLE_INIT, dig_cnt=0, fall_len=0, dig=0, splat=0, illegal=0, asynchronously.
REQ-027 Outputs after reset: ground=NOT HOLE_INIT[START_POS]; bump_* per REQ-015 from current inputs.
REQ-028 Reset asserted mid-fall or mid-dig SHALL abort the operation; no partial column opening persists.
REQ-029 Release of areset_n SHALL take effect at the first rising clk edge with areset_n==1.

Verification
REQ-030 Defaults, walk_left held 8 cycles from pos 8 -> pos reaches 0 after 8 edges, bump_left=1 in that cycle, pos stays 0.
REQ-031 HOLE_INIT=16'h0080, walk_left from pos 8 -> after 1 edge pos=7, ground=0; with aaah held, depth 1..12 over 12 edges, ground=1 at depth 12, splat=0.
REQ-032 digging held 3 cycles at pos 8 -> open[8]=1 after 3rd edge, ground=0; digging dropped after 2 cycles then resumed -> opening needs 3 more.
REQ-033 FLOOR_DEPTH=24, dig opens column, aaah held through landing -> fall_len reaches 24 (>=20), splat=1 at landing edge, stays 1.
REQ-034 walk_left and aaah both 1 for one cycle -> illegal=1 next cycle, persists; dig_req pulse -> dig pulse exactly one cycle later.
REQ-035 areset_n low mid-fall at depth 5 -> depth=0, pos=START_POS, open=HOLE_INIT immediately, before any clk edge.
